sdram_host_arbiter: RTL and testbench



---
 rtl/sdram_arb_pkg.sv | 19 +
 rtl/sdram_arb_watchdog.sv | 42 ++++
 rtl/sdram_host_arbiter.sv | 178 +++++++++++++++++
 tb/tb_sdram_host_arbiter.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sdram_arb_pkg.sv
// Shared definitions for the SDRAM host-port arbiter: FSM state encoding and
// default bus/watchdog sizing used as parameter defaults by the RTL.
// No ports; imported by sdram_arb_watchdog and sdram_host_arbiter.
package sdram_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ISSUE   = 2'd1,
        ST_WAIT    = 2'd2,
        ST_RELEASE = 2'd3
    } arb_state_e;

    localparam int          ARB_ADDR_W      = 23;
    localparam int          ARB_DATA_W      = 16;
    localparam int          ARB_TO_W        = 24;
    // 100 ms at 50 MHz
    localparam logic [23:0] ARB_TIMEOUT_CYC = 24'd5_000_000;

endpackage

// File: rtl/sdram_arb_watchdog.sv
// Watchdog counter: clears on clr_i, counts while en_i, saturates at LIMIT-1.
// Latency: expire_o is combinational from the count register (asserts on the
// LIMIT-th enabled cycle after a clear). No backpressure.
// Ports: CLOCK_50, RESET_n, clr_i (synchronous clear), en_i (count enable),
//        expire_o (count has reached LIMIT-1).
module sdram_arb_watchdog
    import sdram_arb_pkg::*;
#(
    parameter int              TO_W  = ARB_TO_W,
    parameter logic [TO_W-1:0] LIMIT = TO_W'(ARB_TIMEOUT_CYC)
) (
    input  logic CLOCK_50,
    input  logic RESET_n,
    input  logic clr_i,
    input  logic en_i,
    output logic expire_o
);

    localparam logic [TO_W-1:0] CNT_MAX = LIMIT - TO_W'(1);

    logic [TO_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + TO_W'(1);
        end
    end

    always_ff @(posedge CLOCK_50 or negedge RESET_n) begin
        if (!RESET_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expire_o = (cnt_q == CNT_MAX);

endmodule

// File: rtl/sdram_host_arbiter.sv
// Two-requester arbiter/sequencer for the Sdram_Controller host port (LENGTH=1).
// Latency: request->ctl_addr 1 edge, ctl_wr/rd 2 edges; done 1 edge after ctl_done.
// Backpressure: requests are level-held until reqN_done; only sampled in IDLE.
// Ports: reqN_{wr,rd,addr,wdata} in / reqN_{done,rdata} out per requester,
//        ctl_* to/from the controller, busy/grant_id/timeout_err status.
// Build option SDRAM_ARB_FIXED_PRIO_EN: requester 0 wins simultaneous requests
// (default build is round-robin on grant_id).
module sdram_host_arbiter
    import sdram_arb_pkg::*;
#(
    parameter int              ADDR_W      = ARB_ADDR_W,
    parameter int              DATA_W      = ARB_DATA_W,
    parameter int              TO_W        = ARB_TO_W,
    parameter logic [TO_W-1:0] TIMEOUT_CYC = TO_W'(ARB_TIMEOUT_CYC)
) (
    input  logic              CLOCK_50,
    input  logic              RESET_n,
    input  logic              req0_wr,
    input  logic              req0_rd,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [DATA_W-1:0] req0_wdata,
    output logic              req0_done,
    output logic [DATA_W-1:0] req0_rdata,
    input  logic              req1_wr,
    input  logic              req1_rd,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [DATA_W-1:0] req1_wdata,
    output logic              req1_done,
    output logic [DATA_W-1:0] req1_rdata,
    output logic [ADDR_W-1:0] ctl_addr,
    output logic              ctl_wr,
    output logic              ctl_rd,
    output logic [DATA_W-1:0] ctl_datain,
    input  logic              ctl_done,
    input  logic [DATA_W-1:0] ctl_dataout,
    output logic              busy,
    output logic              grant_id,
    output logic              timeout_err
);

    arb_state_e        state_q, state_d;
    logic [ADDR_W-1:0] ctl_addr_q, ctl_addr_d;
    logic [DATA_W-1:0] ctl_datain_q, ctl_datain_d;
    logic              ctl_wr_q, ctl_wr_d;
    logic              ctl_rd_q, ctl_rd_d;
    logic              op_wr_q, op_wr_d;
    logic              grant_id_q, grant_id_d;
    logic              done0_q, done0_d;
    logic              done1_q, done1_d;
    logic [DATA_W-1:0] rdata0_q, rdata0_d;
    logic [DATA_W-1:0] rdata1_q, rdata1_d;
    logic              timeout_err_q, timeout_err_d;

    logic want0, want1, pick1;
    logic wd_clr, wd_en, wd_expire;

    assign want0 = req0_wr | req0_rd;
    assign want1 = req1_wr | req1_rd;

`ifdef SDRAM_ARB_FIXED_PRIO_EN
    assign pick1 = want1 & ~want0;
`else
    // On a tie, serve whoever was not served last.
    assign pick1 = want1 & (~want0 | ~grant_id_q);
`endif

    sdram_arb_watchdog #(
        .TO_W  (TO_W),
        .LIMIT (TIMEOUT_CYC)
    ) u_watchdog (
        .CLOCK_50 (CLOCK_50),
        .RESET_n  (RESET_n),
        .clr_i    (wd_clr),
        .en_i     (wd_en),
        .expire_o (wd_expire)
    );

    always_comb begin
        state_d       = state_q;
        ctl_addr_d    = ctl_addr_q;
        ctl_datain_d  = ctl_datain_q;
        ctl_wr_d      = ctl_wr_q;
        ctl_rd_d      = ctl_rd_q;
        op_wr_d       = op_wr_q;
        grant_id_d    = grant_id_q;
        done0_d       = 1'b0;
        done1_d       = 1'b0;
        rdata0_d      = rdata0_q;
        rdata1_d      = rdata1_q;
        timeout_err_d = timeout_err_q;
        wd_clr        = 1'b0;
        wd_en         = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (want0 || want1) begin
                    ctl_addr_d   = pick1 ? req1_addr  : req0_addr;
                    ctl_datain_d = pick1 ? req1_wdata : req0_wdata;
                    // Write wins when a requester raises both levels.
                    op_wr_d      = pick1 ? req1_wr    : req0_wr;
                    grant_id_d   = pick1;
                    state_d      = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                ctl_wr_d = op_wr_q;
                ctl_rd_d = ~op_wr_q;
                wd_clr   = 1'b1;
                state_d  = ST_WAIT;
            end
            ST_WAIT: begin
                wd_en = 1'b1;
                // ctl_done takes priority so a coincident timeout is a normal completion.
                if (ctl_done || wd_expire) begin
                    ctl_wr_d = 1'b0;
                    ctl_rd_d = 1'b0;
                    done0_d  = ~grant_id_q;
                    done1_d  = grant_id_q;
                    state_d  = ST_RELEASE;
                    if (ctl_done) begin
                        if (!op_wr_q && !grant_id_q) rdata0_d = ctl_dataout;
                        if (!op_wr_q &&  grant_id_q) rdata1_d = ctl_dataout;
                    end else begin
                        timeout_err_d = 1'b1;
                    end
                end
            end
            ST_RELEASE: begin
                // Gives the finished requester one edge to drop its level.
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLOCK_50 or negedge RESET_n) begin
        if (!RESET_n) begin
            state_q       <= ST_IDLE;
            ctl_addr_q    <= '0;
            ctl_datain_q  <= '0;
            ctl_wr_q      <= 1'b0;
            ctl_rd_q      <= 1'b0;
            op_wr_q       <= 1'b0;
            grant_id_q    <= 1'b1;  // requester 0 wins the first tie
            done0_q       <= 1'b0;
            done1_q       <= 1'b0;
            rdata0_q      <= '0;
            rdata1_q      <= '0;
            timeout_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            ctl_addr_q    <= ctl_addr_d;
            ctl_datain_q  <= ctl_datain_d;
            ctl_wr_q      <= ctl_wr_d;
            ctl_rd_q      <= ctl_rd_d;
            op_wr_q       <= op_wr_d;
            grant_id_q    <= grant_id_d;
            done0_q       <= done0_d;
            done1_q       <= done1_d;
            rdata0_q      <= rdata0_d;
            rdata1_q      <= rdata1_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    assign ctl_addr    = ctl_addr_q;
    assign ctl_datain  = ctl_datain_q;
    assign ctl_wr      = ctl_wr_q;
    assign ctl_rd      = ctl_rd_q;
    assign req0_done   = done0_q;
    assign req1_done   = done1_q;
    assign req0_rdata  = rdata0_q;
    assign req1_rdata  = rdata1_q;
    assign grant_id    = grant_id_q;
    assign timeout_err = timeout_err_q;
    assign busy        = (state_q != ST_IDLE);

endmodule

// File: tb/tb_sdram_host_arbiter.sv
// Scoreboard bench for sdram_host_arbiter: directed requests with hand-computed
// expectations queued at issue; a negedge monitor checks controller-side issues,
// WR/RD high time and low gaps, and every reqN_done pulse against the queues.
module tb_sdram_host_arbiter;

    localparam int LAT = 6;

    logic        CLOCK_50 = 1'b0;
    logic        RESET_n;
    logic        req0_wr, req0_rd, req1_wr, req1_rd;
    logic [22:0] req0_addr, req1_addr;
    logic [15:0] req0_wdata, req1_wdata;
    logic        req0_done, req1_done;
    logic [15:0] req0_rdata, req1_rdata;
    logic [22:0] ctl_addr;
    logic        ctl_wr, ctl_rd;
    logic [15:0] ctl_datain;
    logic        ctl_done;
    logic [15:0] ctl_dataout;
    logic        busy, grant_id, timeout_err;

    always #5 CLOCK_50 = ~CLOCK_50;

    sdram_host_arbiter #(
        .ADDR_W      (23),
        .DATA_W      (16),
        .TO_W        (24),
        .TIMEOUT_CYC (24'd100)
    ) dut (
        .CLOCK_50    (CLOCK_50),
        .RESET_n     (RESET_n),
        .req0_wr     (req0_wr),
        .req0_rd     (req0_rd),
        .req0_addr   (req0_addr),
        .req0_wdata  (req0_wdata),
        .req0_done   (req0_done),
        .req0_rdata  (req0_rdata),
        .req1_wr     (req1_wr),
        .req1_rd     (req1_rd),
        .req1_addr   (req1_addr),
        .req1_wdata  (req1_wdata),
        .req1_done   (req1_done),
        .req1_rdata  (req1_rdata),
        .ctl_addr    (ctl_addr),
        .ctl_wr      (ctl_wr),
        .ctl_rd      (ctl_rd),
        .ctl_datain  (ctl_datain),
        .ctl_done    (ctl_done),
        .ctl_dataout (ctl_dataout),
        .busy        (busy),
        .grant_id    (grant_id),
        .timeout_err (timeout_err)
    );

    // ---------------- controller model: DONE LAT cycles after WR/RD rises
    logic        hang;
    int          busy_cnt;
    logic [15:0] mem [logic [22:0]];

    always @(posedge CLOCK_50) begin
        #1;
        if (!RESET_n || !(ctl_wr || ctl_rd)) begin
            busy_cnt = 0;
            ctl_done = 1'b0;
        end else begin
            busy_cnt = busy_cnt + 1;
            ctl_done = 1'b0;
            if (!hang && busy_cnt == LAT) begin
                ctl_done = 1'b1;
                if (ctl_wr) mem[ctl_addr] = ctl_datain;
                else ctl_dataout = mem.exists(ctl_addr) ? mem[ctl_addr]
                                                        : (ctl_addr[15:0] ^ 16'h1234);
            end
        end
    end

    // ---------------- scoreboard
    typedef struct { int id; logic [15:0] rdata; logic to_err; } done_exp_t;
    typedef struct { logic [22:0] addr; logic wr; logic rd; logic [15:0] wdata; int hi; } ctl_exp_t;

    done_exp_t done_q[$];
    ctl_exp_t  ctl_q[$];
    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, required %0h", nm, act, exp);
        end
    endtask

    task automatic push_ctl(input logic [22:0] a, input logic w, input logic r,
                            input logic [15:0] d, input int hi);
        ctl_exp_t e;
        e.addr = a; e.wr = w; e.rd = r; e.wdata = d; e.hi = hi;
        ctl_q.push_back(e);
    endtask

    task automatic push_done(input int id, input logic [15:0] rd, input logic to);
        done_exp_t e;
        e.id = id; e.rdata = rd; e.to_err = to;
        done_q.push_back(e);
    endtask

    task automatic handle_done(input int id, input logic [15:0] rd);
        done_exp_t e;
        if (done_q.size() == 0) begin
            n_cmp++; n_err++;
            $display("FAIL unexpected_done: req%0d_done pulsed, required no pulse", id);
        end else begin
            e = done_q.pop_front();
            check("done_requester", id, e.id);
            check("done_rdata", rd, e.rdata);
            check("done_timeout_err", timeout_err, e.to_err);
            check("done_grant_id", grant_id, e.id);
        end
    endtask

    // ---------------- monitor (samples on the falling edge)
    bit in_txn, have_prev;
    int hi_cnt, low_cnt, cur_hi;

    always @(negedge CLOCK_50) begin
        ctl_exp_t ce;
        if (!RESET_n) begin
            in_txn = 0; have_prev = 0; low_cnt = 0;
        end else begin
            if ((ctl_wr || ctl_rd) && !in_txn) begin
                in_txn = 1; hi_cnt = 1; cur_hi = 0;
                if (have_prev) begin
                    n_cmp++;
                    if (low_cnt < 2) begin
                        n_err++;
                        $display("FAIL wr_rd_low_gap: got %0d cycles, required >= 2", low_cnt);
                    end
                end
                if (ctl_q.size() == 0) begin
                    n_cmp++; n_err++;
                    $display("FAIL unexpected_issue: ctl op at addr %0h, required none", ctl_addr);
                end else begin
                    ce = ctl_q.pop_front();
                    check("issue_addr", ctl_addr, ce.addr);
                    check("issue_wr", ctl_wr, ce.wr);
                    check("issue_rd", ctl_rd, ce.rd);
                    if (ce.wr) check("issue_datain", ctl_datain, ce.wdata);
                    cur_hi = ce.hi;
                end
            end else if (ctl_wr || ctl_rd) begin
                hi_cnt++;
            end else if (in_txn) begin
                in_txn = 0;
                if (cur_hi != 0) check("ctl_high_cycles", hi_cnt, cur_hi);
                have_prev = 1; low_cnt = 1;
            end else begin
                low_cnt++;
            end
            if (req0_done) handle_done(0, req0_rdata);
            if (req1_done) handle_done(1, req1_rdata);
        end
    end

    // ---------------- requester drivers
    task automatic set_req(input int id, input logic w, input logic r,
                           input logic [22:0] a, input logic [15:0] d);
        if (id == 0) begin req0_wr = w; req0_rd = r; req0_addr = a; req0_wdata = d; end
        else         begin req1_wr = w; req1_rd = r; req1_addr = a; req1_wdata = d; end
    endtask

    // Holds the request level across n transactions, dropping it after the last done.
    task automatic drv(input int id, input logic w, input logic r,
                       input logic [22:0] a, input logic [15:0] d, input int n);
        bit got;
        for (int t = 0; t < n; t++) begin
            set_req(id, w, r, a, d);
            got = 0;
            for (int c = 0; c < 400 && !got; c++) begin
                @(posedge CLOCK_50); #1;
                got = (id == 0) ? req0_done : req1_done;
            end
            if (!got) begin
                n_cmp++; n_err++;
                $display("FAIL req%0d_done_wait: no pulse in 400 cycles, required a pulse", id);
            end
        end
        set_req(id, 1'b0, 1'b0, a, d);
    endtask

    task automatic wait_idle();
        for (int c = 0; c < 50; c++) begin
            @(posedge CLOCK_50); #1;
            if (!busy) break;
        end
        repeat (2) @(posedge CLOCK_50);
    endtask

    task automatic do_reset();
        #3 RESET_n = 1'b0;
        repeat (2) @(posedge CLOCK_50);
        #2 RESET_n = 1'b1;
        @(negedge CLOCK_50);
    endtask

    // ---------------- directed sequence
    int ord [4];
    bit seen;

    initial begin
        RESET_n = 1'b0; hang = 1'b0; ctl_done = 1'b0; ctl_dataout = '0;
        set_req(0, 1'b0, 1'b0, '0, '0);
        set_req(1, 1'b0, 1'b0, '0, '0);
        #23;
        check("rst_ctl_wr", ctl_wr, 0);
        check("rst_ctl_rd", ctl_rd, 0);
        check("rst_busy", busy, 0);
        check("rst_grant_id", grant_id, 1);
        check("rst_timeout_err", timeout_err, 0);
        check("rst_done", {req0_done, req1_done}, 0);
        check("rst_rdata", {req0_rdata, req1_rdata}, 0);
        check("rst_ctl_addr", ctl_addr, 0);
        #4 RESET_n = 1'b1;
        @(negedge CLOCK_50);

        // write then read back, requester 0 only
        push_ctl(23'h000100, 1, 0, 16'h5555, LAT); push_done(0, 16'h0000, 0);
        drv(0, 1, 0, 23'h000100, 16'h5555, 1);
        push_ctl(23'h000100, 0, 1, 16'h0000, LAT); push_done(0, 16'h5555, 0);
        drv(0, 0, 1, 23'h000100, 16'h0000, 1);
        wait_idle();

        // simultaneous reads after reset, two per requester
        do_reset();
`ifdef SDRAM_ARB_FIXED_PRIO_EN
        ord = '{0, 0, 1, 1};
`else
        ord = '{0, 1, 0, 1};
`endif
        foreach (ord[i]) begin
            if (ord[i] == 0) begin push_ctl(23'h000200, 0, 1, 0, LAT); push_done(0, 16'h1034, 0); end
            else             begin push_ctl(23'h000300, 0, 1, 0, LAT); push_done(1, 16'h1134, 0); end
        end
        fork
            drv(0, 0, 1, 23'h000200, 16'h0000, 2);
            drv(1, 0, 1, 23'h000300, 16'h0000, 2);
        join
        wait_idle();

        // wr and rd both high on requester 1: write wins
        push_ctl(23'h7FFFFF, 1, 0, 16'hAAAA, LAT); push_done(1, 16'h1134, 0);
        drv(1, 1, 1, 23'h7FFFFF, 16'hAAAA, 1);
        push_ctl(23'h7FFFFF, 0, 1, 16'h0000, LAT); push_done(1, 16'hAAAA, 0);
        drv(1, 0, 1, 23'h7FFFFF, 16'h0000, 1);
        wait_idle();

        // hung controller: watchdog aborts after 100 WAIT cycles
        hang = 1'b1;
        push_ctl(23'h000100, 0, 1, 16'h0000, 100); push_done(0, 16'h1034, 1);
        drv(0, 0, 1, 23'h000100, 16'h0000, 1);
        hang = 1'b0;
        wait_idle();
        check("timeout_err_sticky", timeout_err, 1);
        push_ctl(23'h000100, 0, 1, 16'h0000, LAT); push_done(0, 16'h5555, 1);
        drv(0, 0, 1, 23'h000100, 16'h0000, 1);
        wait_idle();

        // reset mid-WAIT
        hang = 1'b1;
        push_ctl(23'h000400, 1, 0, 16'h1111, 0);
        set_req(0, 1, 0, 23'h000400, 16'h1111);
        seen = 0;
        for (int c = 0; c < 20 && !seen; c++) begin
            @(posedge CLOCK_50); #1;
            seen = ctl_wr;
        end
        check("midwait_wr_seen", seen, 1);
        repeat (3) @(posedge CLOCK_50);
        #3 RESET_n = 1'b0;
        #1;
        check("async_rst_ctl_wr", ctl_wr, 0);
        check("async_rst_busy", busy, 0);
        check("async_rst_timeout_err", timeout_err, 0);
        check("async_rst_grant_id", grant_id, 1);
        set_req(0, 1'b0, 1'b0, '0, '0);
        repeat (2) @(posedge CLOCK_50);
        #2 RESET_n = 1'b1;
        hang = 1'b0;
        @(negedge CLOCK_50);
        push_ctl(23'h000100, 0, 1, 16'h0000, LAT); push_done(0, 16'h5555, 0);
        push_ctl(23'h7FFFFF, 0, 1, 16'h0000, LAT); push_done(1, 16'hAAAA, 0);
        fork
            drv(0, 0, 1, 23'h000100, 16'h0000, 1);
            drv(1, 0, 1, 23'h7FFFFF, 16'h0000, 1);
        join
        wait_idle();
        repeat (4) @(posedge CLOCK_50);

        check("done_queue_drained", done_q.size(), 0);
        check("ctl_queue_drained", ctl_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL global_time_limit: simulation still running at 400000, required completion");
        $fatal(1, "time limit");
    end

endmodule
